multicycle_datapath: RTL

- Multicycle successor to the single-cycle datapath: one register file, one ALU and one shared instruction/data memory port, sequenced by an internal control FSM.
- Parametrised data width.
- Memory accesses use a req/ready handshake, so the block tolerates wait-state memories.
- Sits between the top-level core wrapper and a unified memory model; replaces the separate imem/dmem pairing.

---
 rtl/multicycle_datapath.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-subset core: one regfile, one ALU and one shared memory port (req/ready) under a control FSM.
// Defining PERF_CNT_EN adds the cycle_cnt / instret_cnt counter outputs.
module multicycle_datapath #(
  parameter int           n        = 32,
  parameter logic [n-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  output logic         mem_req,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [n-1:0] pc,
  output logic [3:0]   state,
  output logic         halt
`ifdef PERF_CNT_EN
  ,
  output logic [n-1:0] cycle_cnt,
  output logic [n-1:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_MEMWB  = 4'd5,
    S_ALUWB  = 4'd6,
    S_BRANCH = 4'd7,
    S_JUMP   = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [n-1:0] PC_INC = n'(4);

  state_t       r_state;
  logic [n-1:0] r_pc, r_a, r_b, r_alu_out, r_mdr;
  logic [31:0]  r_ir;
  logic [n-1:0] r_rf [0:31];
  logic         r_halt;

  logic [5:0]   w_op, w_funct;
  logic [4:0]   w_rs, w_rt, w_rd, w_dst;
  logic [n-1:0] w_imm, w_rs_val, w_rt_val, w_jump_tgt, w_alu;
  logic         w_funct_ok, w_illegal;

  assign w_op       = r_ir[31:26];
  assign w_rs       = r_ir[25:21];
  assign w_rt       = r_ir[20:16];
  assign w_rd       = r_ir[15:11];
  assign w_funct    = r_ir[5:0];
  assign w_imm      = {{(n-16){r_ir[15]}}, r_ir[15:0]};
  assign w_rs_val   = (w_rs == 5'd0) ? '0 : r_rf[w_rs];
  assign w_rt_val   = (w_rt == 5'd0) ? '0 : r_rf[w_rt];
  assign w_dst      = (w_op == OP_R) ? w_rd : w_rt;
  // r_pc already holds pc+4 once the instruction is in IR
  assign w_jump_tgt = {r_pc[n-1:28], r_ir[25:0], 2'b00};

  assign w_funct_ok = (w_funct == F_ADD) || (w_funct == F_SUB) || (w_funct == F_AND) ||
                      (w_funct == F_OR)  || (w_funct == F_SLT);
  assign w_illegal  = !(((w_op == OP_R) && w_funct_ok) || (w_op == OP_LW) || (w_op == OP_SW) ||
                        (w_op == OP_BEQ) || (w_op == OP_ADDI) || (w_op == OP_J));

  always_comb begin
    w_alu = r_a + w_imm;
    if (w_op == OP_R) begin
      case (w_funct)
        F_ADD:   w_alu = r_a + r_b;
        F_SUB:   w_alu = r_a - r_b;
        F_AND:   w_alu = r_a & r_b;
        F_OR:    w_alu = r_a | r_b;
        F_SLT:   w_alu = {{(n-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
        default: w_alu = r_a + r_b;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
      r_mdr     <= '0;
      r_halt    <= 1'b0;
      for (int i = 0; i < 32; i++) r_rf[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (mem_ready) begin
          r_ir    <= mem_rdata[31:0];
          r_pc    <= r_pc + PC_INC;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a       <= w_rs_val;
          r_b       <= w_rt_val;
          r_alu_out <= r_pc + (w_imm << 2);
          if (w_illegal) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
          end else if (w_op == OP_BEQ) r_state <= S_BRANCH;
          else if (w_op == OP_J)       r_state <= S_JUMP;
          else                         r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alu_out <= w_alu;
          if (w_op == OP_LW)      r_state <= S_MEMRD;
          else if (w_op == OP_SW) r_state <= S_MEMWR;
          else                    r_state <= S_ALUWB;
        end
        S_MEMRD: if (mem_ready) begin
          r_mdr   <= mem_rdata;
          r_state <= S_MEMWB;
        end
        S_MEMWR: if (mem_ready) r_state <= S_FETCH;
        S_MEMWB: begin
          if (w_rt != 5'd0) r_rf[w_rt] <= r_mdr;
          r_state <= S_FETCH;
        end
        S_ALUWB: begin
          if (w_dst != 5'd0) r_rf[w_dst] <= r_alu_out;
          r_state <= S_FETCH;
        end
        S_BRANCH: begin
          if (r_a == r_b) r_pc <= r_alu_out;
          r_state <= S_FETCH;
        end
        S_JUMP: begin
          r_pc    <= w_jump_tgt;
          r_state <= S_FETCH;
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_state <= S_HALT;
          r_halt  <= 1'b1;
        end
      endcase
    end
  end

  // Request is a pure function of state, held low while reset is asserted
  assign mem_req   = ~rst & ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR));
  assign mem_we    = (r_state == S_MEMWR);
  assign mem_addr  = (r_state == S_FETCH) ? r_pc : r_alu_out;
  assign mem_wdata = r_b;
  assign pc        = r_pc;
  assign state     = r_state;
  assign halt      = r_halt;

`ifdef PERF_CNT_EN
  logic [n-1:0] r_cycle_cnt, r_instret_cnt;
  logic         w_retire;

  assign w_retire = ((r_state == S_MEMWR) && mem_ready) || (r_state == S_MEMWB) ||
                    (r_state == S_ALUWB) || (r_state == S_BRANCH) || (r_state == S_JUMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (w_retire)          r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule
